// File: rtl/clk_div_multi_pkg.sv
// Shared helpers for the multi-channel clock divider.
package clk_div_multi_pkg;

    // Width of a channel index; a single-channel build still gets a 1-bit select.
    function automatic int chanIdxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor-programming port: write strobe, target channel, new divisor and ready.
interface clk_div_multi_if
    import clk_div_multi_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int WIDTH = 16
);
    localparam int CHW = chanIdxWidth(NCH);

    logic             cfg_we;
    logic [CHW-1:0]   cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_we, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_we, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_multi_chan.sv
// One divider channel: counter, active and shadow divisor, enable pulse and square wave.
module clk_div_chan #(
    parameter int WIDTH    = 16,
    parameter int DIV_INIT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             sync_i,
    output logic             pending_o,
    output logic             en_o,
    output logic             clk_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             en_q, en_d;
    logic             clk_q, clk_d;
    logic             wrap;
    logic             apply;
    logic [WIDTH-1:0] divEff;
    logic [WIDTH:0]   halfEff;

    // Next state: a pending divisor swaps in at a wrap, while stopped, or on sync; the high half is sized one bit wider so D=2^WIDTH-1 cannot overflow.
    always_comb begin
        wrap      = (div_q != '0) && (cnt_q == div_q - WIDTH'(1));
        apply     = pending_q && (wrap || (div_q == '0) || sync_i);
        divEff    = apply ? shadow_q : div_q;
        halfEff   = ({1'b0, divEff} + (WIDTH+1)'(1)) >> 1;

        cnt_d     = cnt_q;
        div_d     = divEff;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        en_d      = 1'b0;
        clk_d     = 1'b0;

        if (apply) begin
            pending_d = 1'b0;
        end
        if (wr_i) begin
            shadow_d  = div_i;
            pending_d = 1'b1;
        end

        if (sync_i) begin
            cnt_d = '0;
            en_d  = 1'b0;
            clk_d = (halfEff != '0);
        end else if (apply) begin
            cnt_d = '0;
            en_d  = wrap;
            clk_d = (halfEff != '0);
        end else if (div_q == '0) begin
            cnt_d = '0;
        end else begin
            cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
            en_d  = wrap;
            clk_d = ({1'b0, cnt_d} < halfEff);
        end
    end

    // State register; reset restores the power-on divisor and drops any staged value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= WIDTH'(DIV_INIT);
            shadow_q  <= '0;
            pending_q <= 1'b0;
            en_q      <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            en_q      <= en_d;
            clk_q     <= clk_d;
        end
    end

    assign pending_o = pending_q;
    assign en_o      = en_q;
    assign clk_o     = clk_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock dividers sharing one config port and one sync input.
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int WIDTH    = 16,
    parameter int DIV_INIT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    clk_div_multi_if.slave       cfg,
    input  logic                 sync,
    output logic [NCH-1:0]       pending,
    output logic [NCH-1:0]       en_o,
    output logic [NCH-1:0]       clk_o
);

    localparam int CHW = chanIdxWidth(NCH);

    logic [NCH-1:0] wrStb;

    // Channel decode: an out-of-range channel matches nothing, so ready stays low and the write is dropped.
    always_comb begin
        cfg.cfg_ready = 1'b0;
        wrStb         = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg.cfg_ch == CHW'(i)) begin
                cfg.cfg_ready = ~pending[i];
                wrStb[i]      = cfg.cfg_we & ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : gChan
        clk_div_chan #(
            .WIDTH    (WIDTH),
            .DIV_INIT (DIV_INIT)
        ) uChan (
            .clk       (clk),
            .rst       (rst),
            .wr_i      (wrStb[g]),
            .div_i     (cfg.cfg_div),
            .sync_i    (sync),
            .pending_o (pending[g]),
            .en_o      (en_o[g]),
            .clk_o     (clk_o[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: scoreboarded waveform sequences plus a period/duty table.
module tb_clk_div_multi;
    import clk_div_multi_pkg::*;

    localparam int NCH      = 5;
    localparam int WIDTH    = 8;
    localparam int DIV_INIT = 4;
    localparam int CHW      = chanIdxWidth(NCH);

    logic           clk  = 1'b0;
    logic           rst  = 1'b1;
    logic           sync = 1'b0;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] en_o;
    logic [NCH-1:0] clk_o;

    clk_div_multi_if #(.NCH(NCH), .WIDTH(WIDTH)) cfg ();

    clk_div_multi #(
        .NCH      (NCH),
        .WIDTH    (WIDTH),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg     (cfg.slave),
        .sync    (sync),
        .pending (pending),
        .en_o    (en_o),
        .clk_o   (clk_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             at;
        logic [NCH-1:0] mask;
        logic [NCH-1:0] en;
        logic [NCH-1:0] ck;
        string          tag;
    } expT;

    typedef struct {
        int d;
        int period;
        int highs;
    } perT;

    expT sbq[$];
    int  nTotal = 0;
    int  nBad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nTotal++;
        if (act !== req) begin
            nBad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input bit we, input int ch, input int d, input bit sy);
        cfg.cfg_we  = we;
        cfg.cfg_ch  = CHW'(ch);
        cfg.cfg_div = WIDTH'(d);
        sync        = sy;
    endtask

    task automatic pushExp(input string tag, input int at, input logic [NCH-1:0] mask,
                           input logic [NCH-1:0] en, input logic [NCH-1:0] ck);
        expT e;
        e.at = at; e.mask = mask; e.en = en; e.ck = ck; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic pushBit(input string tag, input int at, input int ch, input bit en, input bit ck);
        logic [NCH-1:0] m;
        logic [NCH-1:0] e;
        logic [NCH-1:0] c;
        m = '0; e = '0; c = '0;
        m[ch] = 1'b1; e[ch] = en; c[ch] = ck;
        pushExp(tag, at, m, e, c);
    endtask

    task automatic waitTo(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic writeDiv(input int ch, input int d);
        int t;
        t = 0;
        cfg.cfg_ch = CHW'(ch);
        #1;
        while (!cfg.cfg_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        checkOutput($sformatf("ready ch%0d", ch), 32'(cfg.cfg_ready), 32'd1);
        applyStimulus(1'b1, ch, d, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, ch, d, 1'b0);
    endtask

    // Scoreboard consumer: compare every entry due this cycle, flag any that slipped past.
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at == cyc) begin
                checkOutput($sformatf("%s en@%0d", sbq[i].tag, cyc),
                            32'(en_o & sbq[i].mask), 32'(sbq[i].en & sbq[i].mask));
                checkOutput($sformatf("%s clk@%0d", sbq[i].tag, cyc),
                            32'(clk_o & sbq[i].mask), 32'(sbq[i].ck & sbq[i].mask));
                sbq.delete(i);
            end else if (sbq[i].at < cyc) begin
                checkOutput($sformatf("%s missed", sbq[i].tag), 32'(cyc), 32'(sbq[i].at));
                sbq.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit  clkRef[4];
        perT perTab[5];
        int  dTab[NCH];
        int  base;
        int  sEdge;
        int  t;
        int  n;
        int  highs;

        clkRef    = '{1'b1, 1'b1, 1'b0, 1'b0};
        perTab[0] = '{1, 1, 1};
        perTab[1] = '{2, 2, 1};
        perTab[2] = '{3, 3, 2};
        perTab[3] = '{6, 6, 3};
        perTab[4] = '{255, 255, 128};
        dTab      = '{3, 4, 6, 7, 4};

        // Reset state
        applyStimulus(1'b0, 0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst en_o", 32'(en_o), 32'd0);
        checkOutput("rst clk_o", 32'(clk_o), 32'd0);
        checkOutput("rst pending", 32'(pending), 32'd0);
        #1;
        checkOutput("rst ready", 32'(cfg.cfg_ready), 32'd1);

        // Release: DIV_INIT=4 on every channel, pulses at edges 4, 8, 12
        @(negedge clk);
        rst  = 1'b0;
        base = cyc;
        for (int k = 1; k <= 12; k++)
            pushExp("rstrel", base + k, '1, (k % 4 == 0) ? '1 : '0, clkRef[k % 4] ? '1 : '0);

        // ch1 gets D=5 mid-period; a second write while pending is dropped
        waitTo(base + 14);
        applyStimulus(1'b1, 1, 5, 1'b0);
        #1;
        checkOutput("B ready before", 32'(cfg.cfg_ready), 32'd1);
        @(negedge clk);
        checkOutput("B pending", 32'(pending[1]), 32'd1);
        #1;
        checkOutput("B ready while pending", 32'(cfg.cfg_ready), 32'd0);
        applyStimulus(1'b1, 1, 7, 1'b0);
        for (int k = 16; k <= 26; k++)
            pushBit("ch1 D5", base + k, 1, ((k - 16) % 5) == 0, ((k - 16) % 5) < 3);
        @(negedge clk);
        applyStimulus(1'b0, 1, 0, 1'b0);
        checkOutput("B pending cleared", 32'(pending[1]), 32'd0);

        // ch2 stopped with D=0 at its wrap, then restarted with D=2
        waitTo(base + 18);
        applyStimulus(1'b1, 2, 0, 1'b0);
        for (int k = 19; k <= 30; k++)
            pushBit("ch2 stop", base + k, 2, k == 20, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 2, 0, 1'b0);
        checkOutput("C pending", 32'(pending[2]), 32'd1);
        waitTo(base + 21);
        checkOutput("C pending cleared", 32'(pending[2]), 32'd0);
        waitTo(base + 30);
        applyStimulus(1'b1, 2, 2, 1'b0);
        #1;
        checkOutput("C ready stopped", 32'(cfg.cfg_ready), 32'd1);
        pushBit("ch2 D2", base + 31, 2, 1'b0, 1'b0);
        for (int k = 32; k <= 40; k++)
            pushBit("ch2 D2", base + k, 2, (k - 32) >= 2 && ((k - 32) % 2) == 0, ((k - 32) % 2) == 0);
        @(negedge clk);
        applyStimulus(1'b0, 2, 0, 1'b0);
        waitTo(base + 41);

        // Sync realignment with D=3,4,6,7 on ch0..3 (ch4 keeps 4)
        for (int i = 0; i < 4; i++) writeDiv(i, dTab[i]);
        applyStimulus(1'b0, 0, 0, 1'b1);
        sEdge = cyc + 1;
        for (int i = 0; i < NCH; i++)
            for (int p = 0; p <= dTab[i]; p++)
                pushBit($sformatf("sync ch%0d", i), sEdge + p, i, p == dTab[i],
                        (p % dTab[i]) < ((dTab[i] + 1) / 2));
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 1'b0);
        checkOutput("sync applied", 32'(pending), 32'd0);
        waitTo(sEdge + 8);

        // Period and high-time table on ch3
        for (int v = 0; v < 5; v++) begin
            writeDiv(3, perTab[v].d);
            applyStimulus(1'b0, 3, 0, 1'b1);
            @(negedge clk);
            applyStimulus(1'b0, 3, 0, 1'b0);
            t = 0;
            while (!en_o[3] && t < 2 * perTab[v].d + 4) begin
                @(negedge clk);
                t++;
            end
            checkOutput($sformatf("D%0d first pulse", perTab[v].d), 32'(en_o[3]), 32'd1);
            n = 0;
            highs = 0;
            do begin
                @(negedge clk);
                n++;
                highs += int'(clk_o[3]);
            end while (!en_o[3] && n < 2 * perTab[v].d + 4);
            checkOutput($sformatf("D%0d period", perTab[v].d), 32'(n), 32'(perTab[v].period));
            checkOutput($sformatf("D%0d high", perTab[v].d), 32'(highs), 32'(perTab[v].highs));
        end

        // Reset while a divisor is pending restores DIV_INIT everywhere
        writeDiv(0, 9);
        checkOutput("F pending", 32'(pending[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("F rst pending", 32'(pending), 32'd0);
        checkOutput("F rst en_o", 32'(en_o), 32'd0);
        rst  = 1'b0;
        base = cyc;
        for (int k = 1; k <= 8; k++)
            pushExp("rst2", base + k, '1, (k % 4 == 0) ? '1 : '0, clkRef[k % 4] ? '1 : '0);
        #1;
        checkOutput("F ready after rst", 32'(cfg.cfg_ready), 32'd1);
        waitTo(base + 9);

        // Out-of-range channel: not ready, write dropped
        applyStimulus(1'b1, 5, 3, 1'b0);
        #1;
        checkOutput("bad ch ready", 32'(cfg.cfg_ready), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 1'b0);
        checkOutput("bad ch pending", 32'(pending), 32'd0);

        @(negedge clk);
        checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
